// File: rtl/tdm_demux_if.sv
// Parallel-side bundle of the TDM receive path.
// Handshake: on each rising clk edge with en=1 the receiver samples din and
// fsync; edges with en=0 are ignored entirely. There is no backpressure:
// valid is a one-cycle strobe meaning y0..y3 have just been replaced by a
// complete frame, and sync_err is a one-cycle strobe flagging a framing error.
// The two strobes are never high together.
interface tdm_demux_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             din;
  logic             fsync;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic             valid;
  logic             sync_err;

  // Link side: drives the serial stream, observes the recovered words.
  modport master (
    output en, din, fsync,
    input  y0, y1, y2, y3, valid, sync_err
  );

  // Demultiplexer side.
  modport slave (
    input  en, din, fsync,
    output y0, y1, y2, y3, valid, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: recovers four WIDTH-bit channel words from a
// serial stream (MSB first, frame marked by fsync on slot 0 bit 0) and
// presents them in parallel, updating all four atomically per frame.
module tdm_demux #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux_if.slave   bus,
  output logic         dbg_state
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [1:0]       slot_cnt;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] stage0;
  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;
  logic [WIDTH-1:0] shifted;

  // Word formed by the bits already collected plus the bit on din now; the
  // shift register keeps only WIDTH-1 bits because the last bit of a slot
  // goes straight into the staging word.
  always_comb begin
    shifted = {shreg, bus.din};
  end

  assign dbg_state = (state == RUN);

  // Framing FSM, counters, staging and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HUNT;
      bit_cnt      <= '0;
      slot_cnt     <= '0;
      shreg        <= '0;
      stage0       <= '0;
      stage1       <= '0;
      stage2       <= '0;
      bus.y0       <= '0;
      bus.y1       <= '0;
      bus.y2       <= '0;
      bus.y3       <= '0;
      bus.valid    <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      bus.valid    <= 1'b0;
      bus.sync_err <= 1'b0;
      if (bus.en) begin
        case (state)
          HUNT: begin
            if (bus.fsync) begin
              shreg    <= shifted[WIDTH-2:0];
              bit_cnt  <= BW'(1);
              slot_cnt <= '0;
              state    <= RUN;
            end
          end
          RUN: begin
            if (slot_cnt == 2'd0 && bit_cnt == '0) begin
              // Frame boundary: fsync is mandatory here, otherwise lock is lost.
              if (!bus.fsync) begin
                bus.sync_err <= 1'b1;
                state        <= HUNT;
              end else begin
                shreg   <= shifted[WIDTH-2:0];
                bit_cnt <= BW'(1);
              end
            end else if (bus.fsync) begin
              // Misplaced fsync: drop the partial frame and restart on this bit.
              bus.sync_err <= 1'b1;
              shreg        <= shifted[WIDTH-2:0];
              bit_cnt      <= BW'(1);
              slot_cnt     <= '0;
            end else if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              shreg   <= shifted[WIDTH-2:0];
              case (slot_cnt)
                2'd0: stage0 <= shifted;
                2'd1: stage1 <= shifted;
                2'd2: stage2 <= shifted;
                default: begin
                  bus.y0    <= stage0;
                  bus.y1    <= stage1;
                  bus.y2    <= stage2;
                  bus.y3    <= shifted;
                  bus.valid <= 1'b1;
                end
              endcase
              slot_cnt <= slot_cnt + 2'd1;
            end else begin
              shreg   <= shifted[WIDTH-2:0];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: receives a serial bit stream carrying four WIDTH-bit channels per frame, marked by a frame-sync strobe, and presents the four channel words in parallel. It is the receive end of the 4-channel selector path: the transmit side time-multiplexes y0..y3 onto one line, and this block recovers them. Sits between the serial link and the parallel channel consumers.

## Interface
- WIDTH, 8, bits per channel slot (≥2); frame length = 4*WIDTH enabled cycles
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- en  input  1  clock enable; din/fsync sampled only on edges with en=1
- din  input  1  serial data, MSB of each slot first
- fsync  input  1  high coincident with bit 0 (MSB) of slot 0 of each frame
- y0, y1, y2, y3  output  WIDTH each  recovered channel words, slot 0..3
- valid  output  1  one-cycle pulse: y0..y3 just updated with a complete frame
- sync_err  output  1  one-cycle pulse: framing error detected

## Operation
- States: HUNT, RUN. Reset state HUNT.
- Counters: bit_cnt 0..WIDTH-1, slot_cnt 0..3; staging shift register (WIDTH) plus three staging words for slots 0..2.
- All actions below happen only on edges with en=1; en=0 freezes state, counters, staging, outputs; valid and sync_err are forced 0 on such edges.
- HUNT: din ignored until fsync=1. On fsync=1: din taken as slot 0 bit 0, bit_cnt=1, slot_cnt=0, go RUN.
- RUN, normal bit: shift din into staging LSB; bit_cnt increments. On bit_cnt=WIDTH-1: completed word moved to staging[slot_cnt] (slots 0..2), bit_cnt wraps to 0, slot_cnt increments.
- RUN, last bit of frame (slot_cnt=3, bit_cnt=WIDTH-1): y0..y2 loaded from staging, y3 loaded from shift register plus this bit, all four together; valid=1. Counters wrap to 0, remain RUN.
- RUN, expected frame start (slot_cnt=0, bit_cnt=0): fsync must be 1. If fsync=0: sync_err=1, bit discarded, go HUNT.
- RUN, fsync=1 at any other position: sync_err=1, partial frame discarded (y* unchanged, no valid), this bit treated as slot 0 bit 0 of a new frame (bit_cnt=1, slot_cnt=0), remain RUN.
- valid and sync_err never high in the same cycle (mid-frame fsync cannot coincide with last bit completion: last-bit fsync=1 is itself a misplaced fsync → error, no valid).
- y0..y3 hold last complete frame indefinitely; never partially updated.

## Timing
- Reset: y0..y3=0, valid=0, sync_err=0, counters=0, HUNT. rst_n=0 mid-frame discards everything at that edge, overriding en.
- Latency: frame words appear on y* and valid high in the cycle immediately after the edge sampling the frame's final bit; valid high exactly one cycle.
- Back-to-back frames: fsync on the very next enabled edge after the last bit continues RUN with no gap; valid spacing = 4*WIDTH enabled cycles.
- sync_err registered, high the cycle after the offending edge.
- en stalls of any length inside a frame are transparent: result identical to un-stalled stream.

## Test plan
- WIDTH=8, reset then frame A5,3C,FF,01 MSB-first with fsync on first bit → after 32nd bit: y0=A5, y1=3C, y2=FF, y3=01, valid one cycle, sync_err=0.
- Two back-to-back frames (A5,3C,FF,01 then 12,34,56,78), en held 1 → valid at cycles 32 and 64 after start, second set replaces first atomically.
- Same frame with en=0 for 3 cycles inside slot 1 and 5 cycles inside slot 3 → identical y* values, valid one cycle after final bit, no pulse during stalls.
- fsync asserted at slot 2 bit 4, then full frame 11,22,33,44 → sync_err one cycle, y* keep prior values, then y0..y3 = 11,22,33,44 after 32 more bits from that fsync with valid.
- After one good frame, fsync missing at next frame start → sync_err one cycle, state HUNT, stream bits ignored until next fsync; following good frame decoded correctly.
- rst_n=0 for one edge at slot 1 bit 3 → y*=0, valid=0, HUNT; bits without fsync produce no valid.
